// File: rtl/idex_hazard_ctrl.sv
// ID/EX interlock controller: load-use stalls, branch flush bubbles and
// registered EX operand forwarding selects from a shadow of in-flight writers.
module idex_hazard_ctrl #(
    parameter int unsigned RFA_W     = 4,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RFA_W-1:0] id_src1,
    input  logic             id_src1_used,
    input  logic [RFA_W-1:0] id_src2,
    input  logic             id_src2_used,
    input  logic [RFA_W-1:0] id_dst,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    output logic             stall_if,
    output logic             flush_ifid,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
    output logic             busy
);

    localparam int unsigned      CNT_W      = 3;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYC - 1);
    localparam logic [1:0]       FWD_GPR    = 2'b00;
    localparam logic [1:0]       FWD_EXMEM  = 2'b01;
    localparam logic [1:0]       FWD_MEMWB  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic             v;
        logic [RFA_W-1:0] dst;
        logic             wr;
        logic             ld;
    } ex_slot_t;

    // A MEM-stage load result is already forwardable, so the load flag is not kept.
    // WB-stage producers are covered by the register file's write-before-read.
    typedef struct packed {
        logic             v;
        logic [RFA_W-1:0] dst;
        logic             wr;
    } mem_slot_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ex_slot_t         ex_q, ex_d;
    mem_slot_t        mem_q, mem_d;
    logic [1:0]       fwd1_q, fwd1_d;
    logic [1:0]       fwd2_q, fwd2_d;
    logic             s1_ex, s2_ex, s1_mem, s2_mem, load_use;

    // Source-to-slot matches; r0 is hardwired and never matches.
    always_comb begin
        s1_ex    = id_src1_used && (id_src1 != '0) && ex_q.v && ex_q.wr && (ex_q.dst == id_src1);
        s2_ex    = id_src2_used && (id_src2 != '0) && ex_q.v && ex_q.wr && (ex_q.dst == id_src2);
        s1_mem   = id_src1_used && (id_src1 != '0) && mem_q.v && mem_q.wr && (mem_q.dst == id_src1);
        s2_mem   = id_src2_used && (id_src2 != '0) && mem_q.v && mem_q.wr && (mem_q.dst == id_src2);
        load_use = id_valid && (s1_ex || s2_ex) && ex_q.ld;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_if    = 1'b0;
        flush_ifid  = 1'b0;
        idex_bubble = 1'b0;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (ex_branch_taken) begin
                    flush_ifid  = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_d       = CNT_RELOAD;
                    state_d     = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
                end else if ((state_q == ST_RUN) && load_use) begin
                    stall_if    = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_ifid  = 1'b1;
                idex_bubble = 1'b1;
                if (ex_branch_taken) begin
                    cnt_d = CNT_RELOAD;
                end else begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Shadow pipeline shift and forward selects for the instruction entering EX.
    always_comb begin
        ex_d.v    = id_valid & ~idex_bubble;
        ex_d.dst  = id_dst;
        ex_d.wr   = id_wr_en;
        ex_d.ld   = id_is_load;
        mem_d.v   = ex_q.v;
        mem_d.dst = ex_q.dst;
        mem_d.wr  = ex_q.wr;
        fwd1_d    = FWD_GPR;
        fwd2_d    = FWD_GPR;
        if (!idex_bubble) begin
            if (s1_ex && !ex_q.ld) begin
                fwd1_d = FWD_EXMEM;
            end else if (s1_mem) begin
                fwd1_d = FWD_MEMWB;
            end
            if (s2_ex && !ex_q.ld) begin
                fwd2_d = FWD_EXMEM;
            end else if (s2_mem) begin
                fwd2_d = FWD_MEMWB;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
            mem_q   <= '0;
            fwd1_q  <= FWD_GPR;
            fwd2_q  <= FWD_GPR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            fwd1_q  <= fwd1_d;
            fwd2_q  <= fwd2_d;
        end
    end

    assign idex_en  = 1'b1;
    assign fwd1_sel = fwd1_q;
    assign fwd2_sel = fwd2_q;
    assign busy     = (state_q != ST_RUN);

endmodule
